// File: rtl/spirose_ram_pkg.sv
// Shared constants and types for the slice RAM write path.
package spirose_ram_pkg;

  localparam int unsigned NB_BLOCKS_DEF        = 15;
  localparam int unsigned PIXELS_PER_BLOCK_DEF = 80;
  localparam int unsigned NB_SLICES_DEF        = 128;

  localparam int unsigned BLK_W   = 4;
  localparam int unsigned PIX_W   = 7;
  localparam int unsigned SLICE_W = 8;
  localparam int unsigned DATA_W  = 24;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } writer_state_e;

endpackage

// File: rtl/ram_addr_counter.sv
// Cascaded pixel/block/slice address counter for the slice RAM writer.
// Outputs reflect the address of the write happening this cycle (after an optional clear).
module ram_addr_counter #(
  parameter int unsigned NbBlocks       = 15,
  parameter int unsigned PixelsPerBlock = 80,
  parameter int unsigned NbSlices       = 128,
  localparam int unsigned PixW   = (PixelsPerBlock > 1) ? $clog2(PixelsPerBlock) : 1,
  localparam int unsigned BlkW   = (NbBlocks > 1) ? $clog2(NbBlocks) : 1,
  localparam int unsigned SliceW = (NbSlices > 1) ? $clog2(NbSlices) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,       // address this cycle starts from zero
  input  logic              inc_i,       // a write consumes the current address
  input  logic              post_clr_i,  // load zero after this cycle regardless of inc_i
  output logic [PixW-1:0]   pix_o,
  output logic [BlkW-1:0]   blk_o,
  output logic [SliceW-1:0] slice_o,
  output logic              pix_wrap_o,
  output logic              slice_wrap_o,
  output logic              frame_wrap_o,
  output logic              final_o      // registered counters sit on the last frame address
);

  logic [PixW-1:0]   pix_q, pix_d, pix_b;
  logic [BlkW-1:0]   blk_q, blk_d, blk_b;
  logic [SliceW-1:0] slice_q, slice_d, slice_b;

  always_comb begin
    pix_b   = clr_i ? '0 : pix_q;
    blk_b   = clr_i ? '0 : blk_q;
    slice_b = clr_i ? '0 : slice_q;

    pix_wrap_o   = (pix_b == PixW'(PixelsPerBlock - 1));
    slice_wrap_o = pix_wrap_o && (blk_b == BlkW'(NbBlocks - 1));
    frame_wrap_o = slice_wrap_o && (slice_b == SliceW'(NbSlices - 1));

    // Independent of clr_i so the top can use it to decide clr_i without a loop.
    final_o = (pix_q == PixW'(PixelsPerBlock - 1)) && (blk_q == BlkW'(NbBlocks - 1)) &&
              (slice_q == SliceW'(NbSlices - 1));

    pix_d   = pix_b;
    blk_d   = blk_b;
    slice_d = slice_b;
    if (post_clr_i) begin
      pix_d   = '0;
      blk_d   = '0;
      slice_d = '0;
    end else if (inc_i) begin
      if (pix_wrap_o) begin
        pix_d = '0;
        if (slice_wrap_o) begin
          blk_d   = '0;
          slice_d = frame_wrap_o ? '0 : slice_b + SliceW'(1);
        end else begin
          blk_d = blk_b + BlkW'(1);
        end
      end else begin
        pix_d = pix_b + PixW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pix_q   <= '0;
      blk_q   <= '0;
      slice_q <= '0;
    end else begin
      pix_q   <= pix_d;
      blk_q   <= blk_d;
      slice_q <= slice_d;
    end
  end

  assign pix_o   = pix_b;
  assign blk_o   = blk_b;
  assign slice_o = slice_b;

endmodule

// File: rtl/ram_stream_writer.sv
// Raster pixel stream to 15-block slice RAM write producer with SOF/EOS pulses.
// Optional dropped-pixel counter enabled by defining RAM_WRITER_DROP_CNT_EN.
module ram_stream_writer
  import spirose_ram_pkg::*;
#(
  parameter int unsigned NB_BLOCKS        = NB_BLOCKS_DEF,
  parameter int unsigned PIXELS_PER_BLOCK = PIXELS_PER_BLOCK_DEF,
  parameter int unsigned NB_SLICES        = NB_SLICES_DEF
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [DATA_W-1:0]  pixel_data,
  output logic [BLK_W-1:0]   block_number,
  output logic [PIX_W-1:0]   pixel_number,
  output logic [DATA_W-1:0]  ram_data,
  output logic               block_write_enable,
  output logic [SLICE_W-1:0] wslice_cnt,
  output logic               SOF,
  output logic               EOS,
  output logic               frame_done,
  output logic               short_frame
`ifdef RAM_WRITER_DROP_CNT_EN
  ,
  output logic [15:0]        dropped_cnt
`endif
);

  localparam int unsigned PixW   = (PIXELS_PER_BLOCK > 1) ? $clog2(PIXELS_PER_BLOCK) : 1;
  localparam int unsigned BlkW   = (NB_BLOCKS > 1) ? $clog2(NB_BLOCKS) : 1;
  localparam int unsigned SliceW = (NB_SLICES > 1) ? $clog2(NB_SLICES) : 1;

  writer_state_e state_q, state_d;

  logic              wr, clr, post_clr, sof, eos, short_pulse, drop;
  logic [PixW-1:0]   cnt_pix;
  logic [BlkW-1:0]   cnt_blk;
  logic [SliceW-1:0] cnt_slice;
  logic              pix_wrap, slice_wrap, frame_wrap, at_final;

  logic [BLK_W-1:0]   blk_q;
  logic [PIX_W-1:0]   pix_q;
  logic [DATA_W-1:0]  data_q;
  logic [SLICE_W-1:0] slice_q;
  logic               we_q, sof_q, eos_q, done_q, short_q;

  ram_addr_counter #(
    .NbBlocks       (NB_BLOCKS),
    .PixelsPerBlock (PIXELS_PER_BLOCK),
    .NbSlices       (NB_SLICES)
  ) u_addr_counter (
    .clk_i        (clk),
    .rst_ni       (nrst),
    .clr_i        (clr),
    .inc_i        (wr),
    .post_clr_i   (post_clr),
    .pix_o        (cnt_pix),
    .blk_o        (cnt_blk),
    .slice_o      (cnt_slice),
    .pix_wrap_o   (pix_wrap),
    .slice_wrap_o (slice_wrap),
    .frame_wrap_o (frame_wrap),
    .final_o      (at_final)
  );

  always_comb begin
    state_d     = state_q;
    wr          = 1'b0;
    clr         = 1'b0;
    post_clr    = 1'b0;
    short_pulse = 1'b0;
    drop        = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (frame_start) begin
          state_d = StWrite;
          clr     = 1'b1;
          wr      = pixel_valid;
        end else begin
          drop = pixel_valid;
        end
      end
      StWrite: begin
        if (frame_start && pixel_valid && at_final) begin
          // Last pixel of the old frame wins this cycle; the new frame starts clean next cycle.
          wr       = 1'b1;
          post_clr = 1'b1;
        end else if (frame_start) begin
          short_pulse = 1'b1;
          clr         = 1'b1;
          wr          = pixel_valid;
        end else begin
          wr = pixel_valid;
        end
      end
      default: state_d = StIdle;
    endcase

    if (wr && frame_wrap && !post_clr) begin
      state_d = StDone;
    end

    sof = wr && (cnt_pix == '0) && (cnt_blk == '0) && (cnt_slice == '0);
    eos = wr && slice_wrap;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      sof_q   <= 1'b0;
      eos_q   <= 1'b0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      blk_q   <= '0;
      pix_q   <= '0;
      slice_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= wr;
      sof_q   <= sof;
      eos_q   <= eos;
      done_q  <= (state_d == StDone);
      short_q <= short_pulse;
      if (wr) begin
        blk_q   <= BLK_W'(cnt_blk);
        pix_q   <= PIX_W'(cnt_pix);
        slice_q <= SLICE_W'(cnt_slice);
        data_q  <= pixel_data;
      end
    end
  end

  assign block_number       = blk_q;
  assign pixel_number       = pix_q;
  assign ram_data           = data_q;
  assign block_write_enable = we_q;
  assign wslice_cnt         = slice_q;
  assign SOF                = sof_q;
  assign EOS                = eos_q;
  assign frame_done         = done_q;
  assign short_frame        = short_q;

`ifdef RAM_WRITER_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      drop_cnt_q <= '0;
    end else if (frame_start) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hffff)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign dropped_cnt = drop_cnt_q;
`else
  logic unused_pix_wrap;
  assign unused_pix_wrap = pix_wrap;
`endif

`ifdef RAM_WRITER_DROP_CNT_EN
  logic unused_pix_wrap;
  assign unused_pix_wrap = pix_wrap;
`endif

endmodule

// File: doc/ram_stream_writer.md
Name: ram_stream_writer

Overview:
Write-side producer for the 15-block slice RAM array. It takes a raster pixel stream (one 24-bit RGB word per valid cycle), splits each slice into 15 blocks of equal length, and emits block number, pixel address, data, write enable and write-slice count. It also emits the SOF/EOS control pulses that the ram_fifo/framebuffer chain consumes. It sits between the video input deserialiser and the RAM/framebuffer array.

Parameters:
NB_BLOCKS, 15, blocks per slice; block_number range is 0..NB_BLOCKS-1.
PIXELS_PER_BLOCK, 80, pixels per block per slice; must be ≤ 128.
NB_SLICES, 128, slices per frame; must be ≤ 256.

Ports:
clk  input  1  system clock
nrst  input  1  asynchronous active-low reset
frame_start  input  1  one-cycle pulse marking start of a frame
pixel_valid  input  1  pixel_data valid this cycle
pixel_data  input  24  RGB pixel
block_number  output  4  target block for the current write
pixel_number  output  7  address inside the block
ram_data  output  24  write data
block_write_enable  output  1  write strobe
wslice_cnt  output  8  slice being written
SOF  output  1  pulse with the first write of a frame
EOS  output  1  pulse with the last write of a slice
frame_done  output  1  level: full frame written, awaiting frame_start
short_frame  output  1  one-cycle pulse: frame_start arrived before frame completion

Behaviour:
- Reset is asynchronous, active-low, on nrst. While in reset, every output is 0, the state is IDLE, and all counters are 0.
- All outputs are registered. Latency from pixel_valid to block_write_enable is 1 cycle. block_number, pixel_number, ram_data and wslice_cnt are valid whenever block_write_enable=1.
- FSM states: IDLE, WRITE, DONE.
- IDLE: pixels are ignored. frame_start moves to WRITE with pix=0, blk=0, slice=0.
- WRITE: on each pixel_valid:
  - write at (blk, pix, slice).
  - pix increments; at PIXELS_PER_BLOCK-1, pix wraps to 0 and blk increments.
  - at blk=NB_BLOCKS-1 with pix at max, EOS=1 for that write, blk wraps to 0 and slice increments.
  - at slice=NB_SLICES-1, the final EOS write moves to DONE.
- SOF=1 on the write of (slice 0, blk 0, pix 0) only.
- DONE: frame_done=1 and pixels are dropped. frame_start moves to WRITE with counters cleared and frame_done cleared on the same edge.
- frame_start in WRITE, unless it coincides with the final EOS pixel: short_frame pulses, counters reset, and the state stays WRITE. The aborted slice gets no EOS.
- frame_start and pixel_valid in the same cycle: the pixel is the first pixel (SOF write) of the new frame, in any state.
- Final-pixel write coinciding with frame_start: EOS for the old frame is issued. The next-cycle write is not possible (one pixel per cycle), so the state becomes WRITE with cleared counters. No short_frame.
- pixel_valid low: no write, no counter change. Gaps are allowed anywhere.
- Width rules: counters are sized from the parameters via $clog2 and zero-extended onto the fixed 4/7/8-bit ports.

Optional Feature:
RAM_WRITER_DROP_CNT_EN:
- Defined: adds output dropped_cnt [15:0]. It is a saturating count of pixel_valid cycles ignored in IDLE/DONE. It clears on reset and on frame_start.
- Undefined: no port and no logic. Behaviour is otherwise identical.

Decomposition:
- Shared package spirose_ram_pkg holds NB_BLOCKS_DEF=15, PIXELS_PER_BLOCK_DEF=80, NB_SLICES_DEF=128, the port width constants (4/7/8/24), and the writer state enum typedef.
- One sub-module, ram_addr_counter: the cascaded pix/blk/slice counter with wrap outputs (pix_wrap, slice_wrap, frame_wrap). The FSM and output registers live in the top.

Test Plan:
- Reset, then frame_start, then 1200 continuous valid pixels: writes (0,0..79) … (14,0..79) at slice 0. SOF on the first write only. EOS on write 1200 (blk 14, pix 79). wslice_cnt=1 from write 1201.
- Full frame of 153600 pixels: EOS pulses 128 times, the last with wslice_cnt=127. frame_done rises the cycle after the last write. Extra pixels produce no writes (dropped_cnt counts them when the macro is defined).
- frame_start after 500 pixels: short_frame=1 for one cycle. The next pixel writes blk 0, pix 0, slice 0 with SOF=1. No EOS is emitted.
- frame_start coincident with pixel_valid in IDLE: that pixel is written at (0,0), slice 0 with SOF=1 one cycle later.
- pixel_valid toggled 1/0 every cycle for one slice: 1200 writes with contiguous addresses and EOS on the 1200th write; write_enable is never high on gap-following cycles without a pixel.
- nrst asserted mid-slice (blk 7, pix 33): all outputs 0 immediately (asynchronously). After release, state is IDLE and pixels are ignored until frame_start.
